biquad_coeff_loader: RTL and testbench
======================================

BIQUAD_COEFF_LOADER -- requirements
Module: biquad_coeff_loader

Interface
REQ-001 Parameter COEFF_W, default 32: width of every coefficient and of wr_data.
REQ-002 Parameter FRAC_BITS, default 16: fractional bits of the signed fixed-point coefficient format (1.0 = 2^FRAC_BITS).
REQ-003 clk  in  1: single clock; all logic on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 wr_valid  in  1: write request.
REQ-006 wr_ready  out  1: write accepted when wr_valid and wr_ready are both high.
REQ-007 wr_addr  in  3: coefficient select. 0=B0, 1=B1, 2=B2, 3=A1, 4=A2; 5-7 are invalid.
REQ-008 wr_data  in  COEFF_W: signed coefficient value.
REQ-009 commit_req  in  1: single-cycle request to apply the shadow set.
REQ-010 sample_strobe  in  1: single-cycle pulse marking the filter sample boundary.
REQ-011 B0, B1, B2, A1, A2  out  COEFF_W each: active signed coefficients driving the biquad.
REQ-012 pending  out  1: high while a validated commit waits for sample_strobe.
REQ-013 coeff_updated  out  1: one-cycle pulse, high in the first cycle new active values are visible.
REQ-014 addr_err  out  1: one-cycle pulse on an accepted write with an invalid address.
REQ-015 commit_err  out  1: one-cycle pulse when a commit fails the stability check.

Function
REQ-016 The block SHALL hold five shadow registers and five active registers, one of each per coefficient.
REQ-017 An accepted write SHALL update the addressed shadow register at that clock edge; active outputs SHALL NOT change.
REQ-018 An accepted write with wr_addr 5-7 SHALL leave all registers unchanged and SHALL pulse addr_err in the next cycle.
REQ-019 FSM states SHALL be IDLE, CHECK and PENDING.
REQ-020 wr_ready SHALL be high only in IDLE.
REQ-021 commit_req in IDLE SHALL move the FSM to CHECK; commit_req in any other state SHALL be ignored.
REQ-022 In CHECK the block SHALL evaluate the shadow set as stable iff |A2| < ONE and |A1| < ONE + A2.
REQ-023 The stability check SHALL use COEFF_W+2-bit signed arithmetic so no operand or sum overflows.
REQ-024 On a pass, CHECK SHALL go to PENDING.
REQ-025 On a fail, CHECK SHALL return to IDLE, pulse commit_err in the next cycle, and leave the shadow registers intact.
REQ-026 sample_strobe in PENDING SHALL copy all five shadow registers to the active registers at that edge, return to IDLE, and pulse coeff_updated in the following cycle.
REQ-027 All five active coefficients SHALL change on the same edge; no torn update is permitted.
REQ-028 sample_strobe outside PENDING SHALL have no effect.
REQ-029 sample_strobe in the same cycle as the IDLE->CHECK transition SHALL NOT apply the commit; the next strobe in PENDING applies it.
REQ-030 A write and commit_req accepted in the same IDLE cycle SHALL both take effect; the checked set includes that write.
REQ-031 pending SHALL equal (state == PENDING).

Reset
REQ-032 On reset, the shadow and active registers SHALL take the passthrough set: B0=ONE, B1=B2=A1=A2=0.
REQ-033 On reset, the FSM SHALL enter IDLE, with wr_ready=1 in the next cycle.
REQ-034 On reset, pending, coeff_updated, addr_err and commit_err SHALL all be 0.
REQ-035 Reset asserted during CHECK or PENDING SHALL abandon the commit; no coeff_updated SHALL follow.

Structure
REQ-036 A shared package SHALL hold the coefficient address enum, COEFF_W, FRAC_BITS, ONE and the passthrough defaults, for reuse by biquad and higher-level control.
REQ-037 The stability check SHALL be a separate combinational sub-module, biquad_stability_check (inputs A1, A2; output stable).

Verification (Q16.16, ONE=0x00010000)
REQ-038 Reset, then 10 idle cycles -> B0=0x00010000, others 0, pending=0, wr_ready=1.
REQ-039 Write B0=0x00008000 and A1=0xFFFF0000 (-1.0) with A2=0x00004000, commit, strobe 5 cycles later -> outputs unchanged until strobe; all five update on the same edge; coeff_updated is a 1-cycle pulse.
REQ-040 Write A2=0x00010000 (1.0), commit -> commit_err pulses, pending never rises, outputs unchanged, wr_ready returns to 1.
REQ-041 Write to wr_addr=6 with data 0x12345678 -> addr_err pulses; all shadow and active values unchanged.
REQ-042 Write B1=0x00002000 and commit_req in the same cycle, with sample_strobe held high every cycle -> wr_ready=0 for the CHECK and PENDING cycles, B1 applied at the first strobe seen in PENDING.
REQ-043 Commit, then assert reset while pending=1 -> passthrough set restored, no coeff_updated pulse, pending=0.

Source files
------------

// File: rtl/biquad_coeff_loader_pkg.sv
// Shared definitions for the biquad coefficient path: addresses, number format
// and the passthrough coefficient set used after reset.
package biquad_coeff_loader_pkg;

    localparam int COEFF_W    = 32;
    localparam int FRAC_BITS  = 16;
    localparam int NUM_COEFFS = 5;

    localparam logic [COEFF_W-1:0] ONE = {{(COEFF_W-1){1'b0}}, 1'b1} << FRAC_BITS;

    typedef enum logic [2:0] {
        ADDR_B0 = 3'd0,
        ADDR_B1 = 3'd1,
        ADDR_B2 = 3'd2,
        ADDR_A1 = 3'd3,
        ADDR_A2 = 3'd4
    } coeff_addr_e;

    localparam logic [COEFF_W-1:0] DEF_B0 = ONE;
    localparam logic [COEFF_W-1:0] DEF_B1 = '0;
    localparam logic [COEFF_W-1:0] DEF_B2 = '0;
    localparam logic [COEFF_W-1:0] DEF_A1 = '0;
    localparam logic [COEFF_W-1:0] DEF_A2 = '0;

endpackage

// File: rtl/biquad_coeff_loader_stability.sv
// Stability triangle test for the feedback pair: |A2| < ONE and |A1| < ONE + A2,
// evaluated two bits wider than the coefficients so nothing can overflow.
module biquad_stability_check #(
    parameter int COEFF_W   = biquad_coeff_loader_pkg::COEFF_W,
    parameter int FRAC_BITS = biquad_coeff_loader_pkg::FRAC_BITS
) (
    input  logic [COEFF_W-1:0] A1,
    input  logic [COEFF_W-1:0] A2,
    output logic               stable
);

    localparam int EXT_W = COEFF_W + 2;
    localparam logic signed [EXT_W-1:0] ONE_EXT = {{(EXT_W-1){1'b0}}, 1'b1} << FRAC_BITS;

    logic signed [EXT_W-1:0] a1_ext;
    logic signed [EXT_W-1:0] a2_ext;
    logic signed [EXT_W-1:0] a1_abs;
    logic signed [EXT_W-1:0] a2_abs;
    logic signed [EXT_W-1:0] a1_limit;

    always_comb begin
        a1_ext   = {{2{A1[COEFF_W-1]}}, A1};
        a2_ext   = {{2{A2[COEFF_W-1]}}, A2};
        a1_abs   = a1_ext[EXT_W-1] ? -a1_ext : a1_ext;
        a2_abs   = a2_ext[EXT_W-1] ? -a2_ext : a2_ext;
        a1_limit = ONE_EXT + a2_ext;
        stable   = (a2_abs < ONE_EXT) && (a1_abs < a1_limit);
    end

endmodule

// File: rtl/biquad_coeff_loader.sv
// Double-buffered biquad coefficient bank: writes land in shadow registers and a
// checked commit copies the whole set to the active outputs on a sample boundary.
module biquad_coeff_loader #(
    parameter int COEFF_W   = biquad_coeff_loader_pkg::COEFF_W,
    parameter int FRAC_BITS = biquad_coeff_loader_pkg::FRAC_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic               commit_req,
    input  logic               sample_strobe,
    output logic [COEFF_W-1:0] B0,
    output logic [COEFF_W-1:0] B1,
    output logic [COEFF_W-1:0] B2,
    output logic [COEFF_W-1:0] A1,
    output logic [COEFF_W-1:0] A2,
    output logic               pending,
    output logic               coeff_updated,
    output logic               addr_err,
    output logic               commit_err
);

    import biquad_coeff_loader_pkg::*;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CHECK   = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    localparam logic [COEFF_W-1:0] ONE_VAL = {{(COEFF_W-1){1'b0}}, 1'b1} << FRAC_BITS;
    localparam logic [4:0][COEFF_W-1:0] PASSTHROUGH = {{(4*COEFF_W){1'b0}}, ONE_VAL};

    logic [1:0]              state_q, state_d;
    logic [4:0][COEFF_W-1:0] shadow_q, shadow_d;
    logic [4:0][COEFF_W-1:0] active_q, active_d;
    logic                    updated_q, updated_d;
    logic                    addr_err_q, addr_err_d;
    logic                    commit_err_q, commit_err_d;
    logic                    wr_fire;
    logic                    stable;

    biquad_stability_check #(
        .COEFF_W   (COEFF_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_stability (
        .A1     (shadow_q[ADDR_A1]),
        .A2     (shadow_q[ADDR_A2]),
        .stable (stable)
    );

    assign wr_ready = (state_q == ST_IDLE);
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        updated_d    = 1'b0;
        addr_err_d   = 1'b0;
        commit_err_d = 1'b0;

        if (wr_fire) begin
            case (wr_addr)
                ADDR_B0: shadow_d[0] = wr_data;
                ADDR_B1: shadow_d[1] = wr_data;
                ADDR_B2: shadow_d[2] = wr_data;
                ADDR_A1: shadow_d[3] = wr_data;
                ADDR_A2: shadow_d[4] = wr_data;
                default: addr_err_d  = 1'b1;
            endcase
        end

        // The check sees shadow_q, which already holds any write accepted alongside commit_req.
        case (state_q)
            ST_IDLE: begin
                if (commit_req) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (stable) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d      = ST_IDLE;
                    commit_err_d = 1'b1;
                end
            end
            ST_PENDING: begin
                if (sample_strobe) begin
                    active_d  = shadow_q;
                    state_d   = ST_IDLE;
                    updated_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shadow_q     <= PASSTHROUGH;
            active_q     <= PASSTHROUGH;
            updated_q    <= 1'b0;
            addr_err_q   <= 1'b0;
            commit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            updated_q    <= updated_d;
            addr_err_q   <= addr_err_d;
            commit_err_q <= commit_err_d;
        end
    end

    assign B0            = active_q[0];
    assign B1            = active_q[1];
    assign B2            = active_q[2];
    assign A1            = active_q[3];
    assign A2            = active_q[4];
    assign pending       = (state_q == ST_PENDING);
    assign coeff_updated = updated_q;
    assign addr_err      = addr_err_q;
    assign commit_err    = commit_err_q;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Bench for biquad_coeff_loader: reference shadow/active model, expected active sets
// queued when a strobe is driven and compared when coeff_updated appears.
module tb_biquad_coeff_loader;

    localparam logic [31:0] ONE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit_req;
    logic        sample_strobe;
    logic [31:0] B0, B1, B2, A1, A2;
    logic        pending;
    logic        coeff_updated;
    logic        addr_err;
    logic        commit_err;

    int checks = 0;
    int passed = 0;

    logic [31:0]  sh_m  [5];
    logic [31:0]  act_m [5];
    logic [159:0] sb_q  [$];
    logic [159:0] exp_set;
    logic [159:0] dut_set;

    assign dut_set = {B0, B1, B2, A1, A2};

    biquad_coeff_loader #(.COEFF_W(32), .FRAC_BITS(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit_req    (commit_req),
        .sample_strobe (sample_strobe),
        .B0            (B0),
        .B1            (B1),
        .B2            (B2),
        .A1            (A1),
        .A2            (A2),
        .pending       (pending),
        .coeff_updated (coeff_updated),
        .addr_err      (addr_err),
        .commit_err    (commit_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [159:0] pack_set(input logic [31:0] m [5]);
        return {m[0], m[1], m[2], m[3], m[4]};
    endfunction

    function automatic bit model_stable(input logic [31:0] a1, input logic [31:0] a2);
        longint s1, s2, m2;
        s1 = longint'($signed(a1));
        s2 = longint'($signed(a2));
        if (s1 < 0) s1 = -s1;
        m2 = (s2 < 0) ? -s2 : s2;
        return (m2 < 65536) && (s1 < 65536 + s2);
    endfunction

    task automatic model_reset();
        sh_m  = '{ONE, 32'h0, 32'h0, 32'h0, 32'h0};
        act_m = '{ONE, 32'h0, 32'h0, 32'h0, 32'h0};
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [31:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
        if (addr < 3'd5) sh_m[addr] = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (coeff_updated !== 1'b0 || addr_err !== 1'b0 || commit_err !== 1'b0) $display("[TB] FAIL reset_pulses: got %b%b%b want 000", coeff_updated, addr_err, commit_err); else passed++;
        reset = 1'b0;
        model_reset();
        tick();
        checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL reset_wr_ready: got %b want 1", wr_ready); else passed++;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (dut_set !== pack_set(act_m)) $display("[TB] FAIL reset_coeffs: got %h want %h", dut_set, pack_set(act_m)); else passed++;
        checks++; if (pending !== 1'b0) $display("[TB] FAIL reset_pending: got %b want 0", pending); else passed++;
    endtask

    task automatic test_commit();
        do_write(3'd0, 32'h0000_8000);
        do_write(3'd3, 32'hFFFF_0000);
        do_write(3'd4, 32'h0000_4000);
        checks++; if (dut_set !== pack_set(act_m)) $display("[TB] FAIL write_no_active: got %h want %h", dut_set, pack_set(act_m)); else passed++;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        checks++; if (wr_ready !== 1'b0) $display("[TB] FAIL check_wr_ready: got %b want 0", wr_ready); else passed++;
        tick();
        checks++; if (pending !== 1'b1) $display("[TB] FAIL commit_pending: got %b want 1", pending); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dut_set !== pack_set(act_m) || coeff_updated !== 1'b0) $display("[TB] FAIL hold_before_strobe: got %h upd %b want %h", dut_set, coeff_updated, pack_set(act_m)); else passed++;
        end
        sb_q.push_back(pack_set(sh_m));
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 0;
        checks++; if (coeff_updated !== 1'b1) $display("[TB] FAIL commit_updated: got %b want 1", coeff_updated); else passed++;
        checks++;
        if (sb_q.size() == 0) $display("[TB] FAIL commit_set: got %h want queued set", dut_set);
        else begin
            exp_set = sb_q.pop_front();
            if (dut_set !== exp_set) $display("[TB] FAIL commit_set: got %h want %h", dut_set, exp_set); else passed++;
        end
        act_m = sh_m;
        checks++; if (pending !== 1'b0) $display("[TB] FAIL commit_pending_clear: got %b want 0", pending); else passed++;
        tick();
        checks++; if (coeff_updated !== 1'b0) $display("[TB] FAIL updated_width: got %b want 0", coeff_updated); else passed++;
    endtask

    task automatic test_stability();
        logic [31:0] tbl_a1 [6] = '{32'h0001_4000, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000};
        logic [31:0] tbl_a2 [6] = '{32'h0000_4000, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_0001, 32'h0000_C000, 32'h0000_4000};
        bit exp_ok;
        for (int k = 0; k < 6; k++) begin
            do_write(3'd3, tbl_a1[k]);
            do_write(3'd4, tbl_a2[k]);
            exp_ok = model_stable(sh_m[3], sh_m[4]);
            commit_req = 1'b1;
            tick();
            commit_req = 1'b0;
            checks++; if (pending !== 1'b0) $display("[TB] FAIL stab%0d_check_pending: got %b want 0", k, pending); else passed++;
            tick();
            checks++; if (commit_err !== !exp_ok) $display("[TB] FAIL stab%0d_commit_err: got %b want %b", k, commit_err, !exp_ok); else passed++;
            checks++; if (pending !== exp_ok) $display("[TB] FAIL stab%0d_pending: got %b want %b", k, pending, exp_ok); else passed++;
            checks++; if (dut_set !== pack_set(act_m)) $display("[TB] FAIL stab%0d_hold: got %h want %h", k, dut_set, pack_set(act_m)); else passed++;
            if (exp_ok) begin
                sb_q.push_back(pack_set(sh_m));
                sample_strobe = 1'b1;
                tick();
                sample_strobe = 1'b0;
                checks++;
                if (coeff_updated !== 1'b1 || sb_q.size() == 0) $display("[TB] FAIL stab%0d_update: got upd %b want 1", k, coeff_updated);
                else begin
                    exp_set = sb_q.pop_front();
                    if (dut_set !== exp_set) $display("[TB] FAIL stab%0d_set: got %h want %h", k, dut_set, exp_set); else passed++;
                end
                act_m = sh_m;
            end else begin
                checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL stab%0d_wr_ready: got %b want 1", k, wr_ready); else passed++;
                tick();
                checks++; if (commit_err !== 1'b0) $display("[TB] FAIL stab%0d_err_width: got %b want 0", k, commit_err); else passed++;
            end
        end
    endtask

    task automatic test_addr_err();
        do_write(3'd6, 32'h1234_5678);
        checks++; if (addr_err !== 1'b1) $display("[TB] FAIL addr_err_pulse: got %b want 1", addr_err); else passed++;
        checks++; if (dut_set !== pack_set(act_m)) $display("[TB] FAIL addr_err_active: got %h want %h", dut_set, pack_set(act_m)); else passed++;
        tick();
        checks++; if (addr_err !== 1'b0) $display("[TB] FAIL addr_err_width: got %b want 0", addr_err); else passed++;
        do_write(3'd2, 32'h0000_0800);
        checks++; if (addr_err !== 1'b0) $display("[TB] FAIL addr_ok_no_err: got %b want 0", addr_err); else passed++;
    endtask

    task automatic test_back_to_back();
        wr_valid      = 1'b1;
        wr_addr       = 3'd1;
        wr_data       = 32'h0000_2000;
        commit_req    = 1'b1;
        sample_strobe = 1'b1;
        tick();
        sh_m[1]    = 32'h0000_2000;
        wr_valid   = 1'b0;
        commit_req = 1'b0;
        checks++; if (wr_ready !== 1'b0 || coeff_updated !== 1'b0) $display("[TB] FAIL b2b_check: got rdy %b upd %b want 0 0", wr_ready, coeff_updated); else passed++;
        sb_q.push_back(pack_set(sh_m));
        tick();
        checks++; if (wr_ready !== 1'b0 || pending !== 1'b1 || coeff_updated !== 1'b0) $display("[TB] FAIL b2b_pending: got rdy %b pend %b upd %b want 0 1 0", wr_ready, pending, coeff_updated); else passed++;
        tick();
        sample_strobe = 1'b0;
        checks++;
        if (coeff_updated !== 1'b1 || sb_q.size() == 0) $display("[TB] FAIL b2b_update: got upd %b want 1", coeff_updated);
        else begin
            exp_set = sb_q.pop_front();
            if (dut_set !== exp_set) $display("[TB] FAIL b2b_set: got %h want %h", dut_set, exp_set); else passed++;
        end
        act_m = sh_m;
        checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL b2b_ready_back: got %b want 1", wr_ready); else passed++;
    endtask

    task automatic test_reset_abort();
        do_write(3'd2, 32'h0000_1111);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        checks++; if (pending !== 1'b1) $display("[TB] FAIL abort_pending_before: got %b want 1", pending); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        checks++; if (pending !== 1'b0 || wr_ready !== 1'b1) $display("[TB] FAIL abort_state: got pend %b rdy %b want 0 1", pending, wr_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (coeff_updated !== 1'b0 || dut_set !== pack_set(act_m)) $display("[TB] FAIL abort_quiet: got upd %b set %h want 0 %h", coeff_updated, dut_set, pack_set(act_m)); else passed++;
            tick();
        end
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        sb_q.push_back(pack_set(sh_m));
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        checks++;
        if (coeff_updated !== 1'b1 || sb_q.size() == 0) $display("[TB] FAIL abort_shadow_update: got upd %b want 1", coeff_updated);
        else begin
            exp_set = sb_q.pop_front();
            if (dut_set !== exp_set) $display("[TB] FAIL abort_shadow_set: got %h want %h", dut_set, exp_set); else passed++;
        end
    endtask

    initial begin
        reset         = 1'b1;
        wr_valid      = 1'b0;
        wr_addr       = 3'd0;
        wr_data       = 32'h0;
        commit_req    = 1'b0;
        sample_strobe = 1'b0;
        model_reset();

        test_reset();
        test_commit();
        test_stability();
        test_addr_err();
        test_back_to_back();
        test_reset_abort();

        checks++; if (sb_q.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); else passed++;
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
